// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready payload stage with a 2-entry skid
// buffer, global halt, synchronous flush and saturating back-pressure counters.
module pipe_stage_skid #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_sys,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] in_stall_cnt
);

  // Handshake: a beat moves across a port on a rising edge where valid and
  // ready are both high at that edge; valid never depends on ready on the same
  // port, and in_ready never depends on out_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] out_stall_cnt_q, out_stall_cnt_d;
  logic [CNT_W-1:0] in_stall_cnt_q, in_stall_cnt_d;
  logic             acc;
  logic             emit;

  assign in_ready      = (state_q != FULL) && !halt_sys && !flush;
  assign out_valid     = (state_q != EMPTY) && !halt_sys;
  assign acc           = in_valid && in_ready;
  assign emit          = out_valid && out_ready;
  assign out_data      = main_q;
  assign occupancy     = state_q;
  assign out_stall_cnt = out_stall_cnt_q;
  assign in_stall_cnt  = in_stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only drops the state; the data registers keep stale contents.
    if (!halt_sys) begin
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (acc) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (acc && !emit) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (emit && !acc) begin
              state_d = EMPTY;
            end else if (acc && emit) begin
              main_d = in_data;
            end
          end
          FULL: begin
            if (emit) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    out_stall_cnt_d = out_stall_cnt_q;
    in_stall_cnt_d  = in_stall_cnt_q;
    if (out_valid && !out_ready && (out_stall_cnt_q != CNT_MAX)) begin
      out_stall_cnt_d = out_stall_cnt_q + CNT_ONE;
    end
    if (in_valid && !in_ready && !halt_sys && (in_stall_cnt_q != CNT_MAX)) begin
      in_stall_cnt_d = in_stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= EMPTY;
      main_q          <= '0;
      skid_q          <= '0;
      out_stall_cnt_q <= '0;
      in_stall_cnt_q  <= '0;
    end else begin
      state_q         <= state_d;
      main_q          <= main_d;
      skid_q          <= skid_d;
      out_stall_cnt_q <= out_stall_cnt_d;
      in_stall_cnt_q  <= in_stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: expected beats queued at stimulus time and
// popped by a negedge monitor on every downstream handshake.
module tb_pipe_stage_skid;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halt_sys = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  out_stall_cnt, in_stall_cnt;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occupancy;
  logic [1:0]   s_out_stall_cnt, s_in_stall_cnt;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .out_stall_cnt(out_stall_cnt), .in_stall_cnt(in_stall_cnt)
  );

  pipe_stage_skid #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .out_stall_cnt(s_out_stall_cnt), .in_stall_cnt(s_in_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt_sys = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    #3 rst = 1'b0;
    step();
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_complete", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  // Monitor: inputs change only at posedge+1, so negedge values are what the next edge sees.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, out_data}, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_order", {24'd0, out_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("reset_occ", occupancy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_stall", out_stall_cnt, 0);
    chk("reset_in_stall", in_stall_cnt, 0);

    // Streaming 0x11..0x18 at full rate, one cycle latency.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = W'(8'h11 + i);
      exp_q.push_back(W'(8'h11 + i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 32'h11 + i);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty_q", exp_q.size(), 0);
    chk("stream_occ", occupancy, 0);
    chk("stream_out_stall", out_stall_cnt, 0);
    chk("stream_in_stall", in_stall_cnt, 0);

    // Back-pressure: A,B,C with out_ready low for three valid cycles.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h0A; exp_q.push_back(8'h0A);
    step();
    in_data = 8'h0B; exp_q.push_back(8'h0B);
    step();
    chk("bp_occ_full", occupancy, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_main_a", out_data, 8'h0A);
    in_data = 8'h0C; exp_q.push_back(8'h0C);
    step();
    step();
    chk("bp_out_stall", out_stall_cnt, 3);
    chk("bp_in_stall_mid", in_stall_cnt, 2);
    out_ready = 1'b1;
    step();
    chk("bp_one_after_emit", occupancy, 1);
    chk("bp_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    step();
    chk("bp_empty_q", exp_q.size(), 0);
    chk("bp_out_stall_final", out_stall_cnt, 3);
    chk("bp_in_stall_final", in_stall_cnt, 3);

    // Flush while full, with a beat offered in the flush cycle.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    chk("fl_occ_full", occupancy, 2);
    in_data = 8'h03;
    flush = 1'b1;
    #1 chk("fl_in_ready_low", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ_zero", occupancy, 0);
    chk("fl_out_valid_low", out_valid, 0);
    chk("fl_data_kept", out_data, 8'h01);
    chk("fl_out_stall_kept", out_stall_cnt, 2);
    chk("fl_in_stall_kept", in_stall_cnt, 1);
    in_valid = 1'b1;
    in_data = 8'h04; exp_q.push_back(8'h04);
    step();
    in_valid = 1'b0;
    chk("fl_beat4", out_data, 8'h04);
    drain();

    // Halt for four cycles with 0x5 pending; flush raised mid-halt is ignored.
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h05; exp_q.push_back(8'h05);
    step();
    halt_sys = 1'b1;
    in_data = 8'h06;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      flush = (c == 1);
      #1;
      chk("halt_in_ready", in_ready, 0);
      chk("halt_out_valid", out_valid, 0);
      step();
      chk("halt_occ", occupancy, 1);
      chk("halt_data", out_data, 8'h05);
      chk("halt_out_stall", out_stall_cnt, 0);
      chk("halt_in_stall", in_stall_cnt, 0);
    end
    halt_sys = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1 chk("halt_release_valid", out_valid, 1);
    drain();
    chk("halt_done_occ", occupancy, 0);

    // Saturation on the CNT_W=2 instance.
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h07; exp_q.push_back(8'h07);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_cnt2", s_out_stall_cnt, (i + 1 > 3) ? 3 : i + 1);
      chk("sat_cnt16", out_stall_cnt, i + 1);
    end
    drain();

    // Asynchronous reset mid-cycle with a beat held.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h09;
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", occupancy, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_out_stall", out_stall_cnt, 0);
    chk("ar_sat_stall", s_out_stall_cnt, 0);
    #3 rst = 1'b0;
    step();
    chk("ar_after_occ", occupancy, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline-stage register for the datapath stage boundaries. It is the drop-in successor to the fixed stage flops. It carries an arbitrary-width payload with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` has no combinational path from `out_ready`. It supports global halt, synchronous flush, and saturating back-pressure counters for performance debug.

## Interface
Parameters:
- `WIDTH`, default 32: payload width in bits (≥1).
- `CNT_W`, default 16: width of each stall counter (≥2).

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `halt_sys`, in, 1: global freeze; no state change while high.
- `flush`, in, 1: synchronous discard of all held beats.
- `in_valid`, in, 1: upstream beat present.
- `in_ready`, out, 1: stage can accept a beat this cycle.
- `in_data`, in, WIDTH: upstream payload.
- `out_valid`, out, 1: beat presented downstream.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_data`, out, WIDTH: downstream payload; always equals the main register.
- `occupancy`, out, 2: number of held beats (0..2).
- `out_stall_cnt`, out, CNT_W: cycles with `out_valid & !out_ready`.
- `in_stall_cnt`, out, CNT_W: cycles with `in_valid & !in_ready`.

## Operation
- Storage: main register (`out_data` source) plus skid register. State is EMPTY (occ 0), ONE (occ 1) or FULL (occ 2).
- Combinational outputs:
  - `in_ready = (state != FULL) & !halt_sys & !flush`.
  - `out_valid = (state != EMPTY) & !halt_sys`.
- Handshake events: `acc = in_valid & in_ready`; `emit = out_valid & out_ready`.
- Transitions, evaluated when `!halt_sys & !flush`:
  - EMPTY: `acc` → ONE, main ← `in_data`.
  - ONE, `acc & !emit`: → FULL, skid ← `in_data`.
  - ONE, `emit & !acc`: → EMPTY.
  - ONE, `acc & emit`: stays ONE, main ← `in_data`.
  - FULL, `emit`: → ONE, main ← skid. `acc` cannot occur in FULL.
- Beats leave in strict arrival order; no beat is duplicated or lost except by `flush`.
- Flush:
  - State → EMPTY next cycle.
  - `in_ready` is 0 that cycle, so no beat is accepted.
  - Data registers keep their values but are invalid.
  - Counters are unaffected.
- Halt:
  - Overrides flush; flush is ignored while `halt_sys` is high.
  - All registers and counters hold.
  - `in_ready` = 0 and `out_valid` = 0.
- Counters:
  - `out_stall_cnt` increments when `out_valid & !out_ready`.
  - `in_stall_cnt` increments when `in_valid & !in_ready & !halt_sys`.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - Both are cleared only by `rst`.
- Reset values: state EMPTY, main and skid = 0, `occupancy` = 0, `in_ready` = 1 (subject to halt/flush), `out_valid` = 0, `out_data` = 0, counters = 0.

## Timing
- Latency: a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N; 1 cycle through an empty stage.
- Throughput: 1 beat/cycle sustained when `out_ready` stays high.
- `in_ready` depends only on registered state, `halt_sys` and `flush`. There is no `out_ready` → `in_ready` path.
- One cycle of downstream back-pressure is absorbed by the skid register; `in_ready` drops the cycle after the stage reaches FULL.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously); held beats are lost.
- `occupancy` is registered and changes only on clock edges.

## Test plan
- Streaming: `out_ready` = 1, beats 0x11..0x18 on consecutive cycles → the same 8 beats appear in order, one per cycle, 1 cycle later. Both counters stay 0.
- Back-pressure:
  - Stimulus: send 0xA, 0xB, 0xC with `out_ready` = 0 for 3 cycles, then 1.
  - `occupancy` reaches 2 and `in_ready` drops, so 0xC is held upstream.
  - Output order is 0xA, 0xB, 0xC.
  - `out_stall_cnt` = 3; `in_stall_cnt` counts the cycles 0xC waits.
- Flush:
  - Stimulus: fill to FULL (0x1, 0x2), then assert `flush` together with `in_valid` (0x3).
  - Next cycle `occupancy` = 0 and `out_valid` = 0; 0x3 is not accepted.
  - A subsequent beat 0x4 is output correctly.
- Halt:
  - Stimulus: assert `halt_sys` for 4 cycles with `out_valid` pending 0x5.
  - `in_ready` = 0, `out_valid` = 0, counters frozen.
  - After release, 0x5 emits unchanged.
- Saturation and reset:
  - With CNT_W = 2, hold `out_ready` = 0 for 6 cycles → `out_stall_cnt` = 3.
  - Async `rst` pulse mid-cycle → all outputs at reset values before the next edge.
